conv3x3_stream_core: RTL and testbench

Parametrised streaming 3x3 convolution engine, successor to the fixed 8-wide, 3-channel conv front end of the CNN top.
- Accepts a serial weight load, then a raster-scan pixel stream through a single byte port.
- Computes CH output channels per valid window position in a 2-stage pipeline.
- Emits requantised, saturated results with a frame-done marker.
- Sits between the input mux (mode/ram_en) and the pooling/connect stages.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/conv3x3_mac.sv | 47 ++++
 rtl/conv3x3_stream_core.sv | 116 +++++++++++
 tb/tb_conv3x3_stream_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared definitions for the CNN conv front end.
//   MODE_WEIGHT / MODE_DATA : encodings of the 'mode' input
//   tap_idx()               : line-buffer index of 3x3 window tap (i,j)
//   sat_shift()             : arithmetic right shift then saturate to dw bits
package cnn_pkg;

    localparam logic MODE_WEIGHT = 1'b0;
    localparam logic MODE_DATA   = 1'b1;

    // Tap (i,j) with i = window row (0 = top), j = window column (0 = left).
    // sr[0] holds the newest pixel, so the bottom-right tap is index 0.
    function automatic int tap_idx(input int i, input int j, input int img_w);
        return (2 - i) * img_w + (2 - j);
    endfunction

    // Works on a 64-bit sign-extended accumulator so one function serves any
    // ACC_W; the caller keeps the low dw bits of the clamped result.
    function automatic logic signed [31:0] sat_shift(input logic signed [63:0] acc,
                                                     input int sh, input int dw);
        logic signed [63:0] s, hi, lo;
        s  = acc >>> sh;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return s[31:0];
    endfunction

endpackage

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: one output channel of the 3x3 convolution.
//   clk, rst_n : clock, async active-low reset
//   taps, wts  : 9 signed pixels / weights, index k = i*3+j
//   res        : requantised, saturated result (2 cycles after taps/wts)
// Optional: CONV_RELU_EN clamps negative results to 0.
module conv3x3_mac
    import cnn_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 21,
    parameter int SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8:0][DW-1:0]   taps,
    input  logic [8:0][DW-1:0]   wts,
    output logic [DW-1:0]        res
);

    logic signed [2*DW-1:0] prod [9];
    logic signed [ACC_W-1:0] acc;
    logic signed [31:0]      sat;

    always_comb begin
        acc = '0;
        for (int k = 0; k < 9; k++)
            acc = acc + ACC_W'(prod[k]);
        sat = sat_shift(64'(acc), SHIFT, DW);
`ifdef CONV_RELU_EN
        if (sat < 0)
            sat = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++)
                prod[k] <= '0;
            res <= '0;
        end else begin
            for (int k = 0; k < 9; k++)
                prod[k] <= $signed(taps[k]) * $signed(wts[k]);
            res <= sat[DW-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_stream_core.sv
// conv3x3_stream_core: streaming 3x3 convolution, CH output channels.
//   clk, rst_n  : clock, async active-low reset
//   mode        : MODE_WEIGHT = serial weight load, MODE_DATA = pixel stream
//   ram_en, din : input strobe and signed weight/pixel
//   wt_ready    : all 9*CH weights loaded (sticky until reset)
//   out_vld     : dout valid, 2 cycles after the window-completing pixel
//   dout        : channel c at [c*DW +: DW]
//   frame_done  : with out_vld of the last window of a frame
// Optional: CONV_RELU_EN (clamp negative results to 0, inside conv3x3_mac).
module conv3x3_stream_core
    import cnn_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CH    = 3,
    parameter int DW    = 8,
    parameter int ACC_W = 21,
    parameter int SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 ram_en,
    input  logic [DW-1:0]        din,
    output logic                 wt_ready,
    output logic                 out_vld,
    output logic [CH*DW-1:0]     dout,
    output logic                 frame_done
);

    localparam int NW     = 9 * CH;
    localparam int LB     = 2 * IMG_W + 3;
    localparam int WCW    = $clog2(NW);
    localparam int CW     = $clog2(IMG_W);
    localparam int RW     = $clog2(IMG_H);
    localparam int STAGES = 2;

    logic [DW-1:0]       wt [NW];
    logic [DW-1:0]       sr [LB];
    logic [WCW-1:0]      wcnt;
    logic [CW-1:0]       col;
    logic [RW-1:0]       row;
    logic [STAGES:0]     vld_pipe;
    logic [STAGES:0]     last_pipe;

    logic wr_en, px_en, win_vld, win_last;

    assign wr_en    = ram_en && (mode == MODE_WEIGHT);
    assign px_en    = ram_en && (mode == MODE_DATA) && wt_ready;
    // Judged on the counters before the accepted pixel advances them.
    assign win_vld  = px_en && (row >= RW'(2)) && (col >= CW'(2));
    assign win_last = win_vld && (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt      <= '0;
            wt_ready  <= 1'b0;
            col       <= '0;
            row       <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int k = 0; k < NW; k++)
                wt[k] <= '0;
            for (int k = 0; k < LB; k++)
                sr[k] <= '0;
        end else if (wr_en) begin
            // A weight write aborts any partial frame and in-flight results.
            wt[wcnt] <= din;
            if (wcnt == WCW'(NW - 1)) begin
                wcnt     <= '0;
                wt_ready <= 1'b1;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
            col       <= '0;
            row       <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], win_vld};
            last_pipe <= {last_pipe[STAGES-1:0], win_last};
            if (px_en) begin
                sr[0] <= din;
                for (int k = 1; k < LB; k++)
                    sr[k] <= sr[k-1];
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // vld_pipe[0] is set at the accept edge; the MAC registers its products
    // one edge later and its result the edge after that.
    assign out_vld    = vld_pipe[STAGES];
    assign frame_done = last_pipe[STAGES];

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [8:0][DW-1:0] taps, wts;
        for (genvar k = 0; k < 9; k++) begin : g_tap
            assign taps[k] = sr[tap_idx(k / 3, k % 3, IMG_W)];
            assign wts[k]  = wt[c * 9 + k];
        end
        conv3x3_mac #(.DW(DW), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .taps  (taps),
            .wts   (wts),
            .res   (dout[c*DW +: DW])
        );
    end

endmodule

// File: tb/tb_conv3x3_stream_core.sv
module tb_conv3x3_stream_core;

    localparam int W = 4, H = 4, CH = 2, DW = 8, ACC_W = 21, SHIFT = 4;
    localparam int NW = 9 * CH;

    logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, ram_en = 1'b0;
    logic [DW-1:0] din = '0;
    logic wt_ready, out_vld, frame_done;
    logic [CH*DW-1:0] dout;

    conv3x3_stream_core #(.IMG_W(W), .IMG_H(H), .CH(CH), .DW(DW),
                          .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ram_en(ram_en), .din(din),
        .wt_ready(wt_ready), .out_vld(out_vld), .dout(dout), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed results, written only by the monitor.
    logic [CH*DW-1:0] obs_d [256];
    logic             obs_fd [256];
    int               obs_cyc [256];
    int               n_obs = 0;
    always @(negedge clk)
        if ((out_vld || frame_done) && n_obs < 256) begin
            obs_d[n_obs]   <= dout;
            obs_fd[n_obs]  <= frame_done;
            obs_cyc[n_obs] <= cyc;
            n_obs          <= n_obs + 1;
        end

    // Reference model state.
    typedef struct { logic [CH*DW-1:0] d; logic fd; int due; } exp_t;
    exp_t exp_q [$];
    logic signed [DW-1:0] mw [NW];
    logic signed [DW-1:0] img [H][W];
    logic signed [DW-1:0] nw [NW];
    int  mwcnt = 0, mrow = 0, mcol = 0;
    bit  mready = 0;
    int  rd = 0;
    int  vectors = 0, miscompares = 0;

    function automatic logic [CH*DW-1:0] model_out(input int r, input int c);
        logic [CH*DW-1:0] d;
        int s;
        d = '0;
        for (int ch = 0; ch < CH; ch++) begin
            s = 0;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    s += int'(mw[ch*9 + i*3 + j]) * int'(img[r-2+i][c-2+j]);
            s = s >>> SHIFT;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
`ifdef CONV_RELU_EN
            if (s < 0) s = 0;
`endif
            d[ch*DW +: DW] = 8'(s);
        end
        return d;
    endfunction

    task automatic model_reset();
        mwcnt = 0; mrow = 0; mcol = 0; mready = 0;
        for (int k = 0; k < NW; k++) mw[k] = '0;
        exp_q.delete();
    endtask

    task automatic drive_wt(input logic [DW-1:0] w);
        @(negedge clk);
        mode = 1'b0; ram_en = 1'b1; din = w;
        @(posedge clk); #1;
        mw[mwcnt] = w;
        mwcnt = (mwcnt == NW - 1) ? 0 : mwcnt + 1;
        if (mwcnt == 0) mready = 1;
        mrow = 0; mcol = 0;
        for (int k = exp_q.size() - 1; k >= 0; k--)
            if (exp_q[k].due >= cyc) exp_q.delete(k);
    endtask

    task automatic drive_px(input logic [DW-1:0] px);
        exp_t e;
        @(negedge clk);
        mode = 1'b1; ram_en = 1'b1; din = px;
        @(posedge clk); #1;
        if (mready) begin
            img[mrow][mcol] = px;
            if (mrow >= 2 && mcol >= 2) begin
                e.d = model_out(mrow, mcol);
                e.fd = (mrow == H - 1 && mcol == W - 1);
                e.due = cyc + 2;
                exp_q.push_back(e);
            end
            if (mcol == W - 1) begin
                mcol = 0;
                mrow = (mrow == H - 1) ? 0 : mrow + 1;
            end else mcol++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ram_en = 1'b0;
        end
    endtask

    task automatic load_nw(input int n);
        for (int k = 0; k < n; k++) drive_wt(nw[k]);
    endtask

    task automatic rand_nw();
        for (int k = 0; k < NW; k++) nw[k] = 8'($urandom);
    endtask

    task automatic send_frame(input bit gap, input bit rnd, input logic [DW-1:0] val);
        for (int p = 0; p < W * H; p++) begin
            drive_px(rnd ? 8'($urandom) : val);
            if (gap) idle(1);
        end
    endtask

    task automatic check_results(input string name);
        int n;
        idle(5);
        #1;
        n = n_obs - rd;
        vectors++;
        if (n != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s result count: got %0d want %0d", name, n, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < n; k++) begin
            vectors += 3;
            if (obs_d[rd+k] !== exp_q[k].d) begin
                miscompares++;
                $display("FAIL %s dout[%0d]: got %h want %h", name, k, obs_d[rd+k], exp_q[k].d);
            end
            if (obs_fd[rd+k] !== exp_q[k].fd) begin
                miscompares++;
                $display("FAIL %s frame_done[%0d]: got %b want %b", name, k, obs_fd[rd+k], exp_q[k].fd);
            end
            if (obs_cyc[rd+k] != exp_q[k].due) begin
                miscompares++;
                $display("FAIL %s timing[%0d]: got cycle %0d want %0d", name, k, obs_cyc[rd+k], exp_q[k].due);
            end
        end
        rd = n_obs;
        exp_q.delete();
    endtask

    task automatic check_const(input string name, input int first, input int cnt,
                               input logic [CH*DW-1:0] want);
        for (int k = first; k < first + cnt; k++) begin
            vectors++;
            if (k >= n_obs || obs_d[k] !== want) begin
                miscompares++;
                $display("FAIL %s const[%0d]: got %h want %h", name, k - first, obs_d[k], want);
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; ram_en = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd = n_obs;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors += 4;
        if (wt_ready !== 1'b0) begin miscompares++; $display("FAIL reset wt_ready: got %b want 0", wt_ready); end
        if (out_vld !== 1'b0) begin miscompares++; $display("FAIL reset out_vld: got %b want 0", out_vld); end
        if (dout !== '0) begin miscompares++; $display("FAIL reset dout: got %h want 0", dout); end
        if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
        apply_reset();
    endtask

    task automatic test_basic();
        int first;
        for (int k = 0; k < NW; k++) nw[k] = (k < 9 || k == 9 + 4) ? 8'sd1 : 8'sd0;
        load_nw(NW);
        first = rd;
        send_frame(0, 0, 8'd16);
        check_results("basic");
        check_const("basic", first, 4, 16'h0109);
        vectors++;
        if (n_obs - first != 4 || obs_fd[first+3] !== 1'b1) begin
            miscompares++;
            $display("FAIL basic fd4: got count %0d fd %b want 4 1", n_obs - first, obs_fd[first+3]);
        end
    endtask

    task automatic test_saturation();
        int first;
        for (int k = 0; k < NW; k++) nw[k] = 8'sd127;
        load_nw(NW);
        first = rd;
        send_frame(0, 0, 8'd127);
        check_results("sat_pos");
        check_const("sat_pos", first, 4, 16'h7f7f);
        for (int k = 0; k < NW; k++) nw[k] = 8'h80;
        load_nw(NW);
        first = rd;
        send_frame(0, 0, 8'd127);
        check_results("sat_neg");
`ifdef CONV_RELU_EN
        check_const("sat_neg", first, 4, 16'h0000);
`else
        check_const("sat_neg", first, 4, 16'h8080);
`endif
    endtask

    task automatic test_no_weights();
        apply_reset();
        rand_nw();
        load_nw(NW - 1);
        for (int p = 0; p < 12; p++) drive_px(8'($urandom));
        idle(1);
        vectors++;
        if (wt_ready !== 1'b0) begin miscompares++; $display("FAIL nowt wt_ready: got %b want 0", wt_ready); end
        check_results("nowt_ignored");
        drive_wt(nw[NW-1]);
        idle(1);
        vectors++;
        if (wt_ready !== 1'b1) begin miscompares++; $display("FAIL nowt wt_ready rise: got %b want 1", wt_ready); end
        send_frame(0, 1, '0);
        check_results("nowt_frame");
    endtask

    task automatic test_gaps();
        rand_nw();
        load_nw(NW);
        send_frame(1, 1, '0);
        check_results("gaps");
        for (int p = 0; p < W * H; p++) begin
            drive_px(8'($urandom));
            idle($urandom_range(0, 3));
        end
        check_results("rand_gaps");
    endtask

    task automatic test_reset_midframe();
        rand_nw();
        load_nw(NW);
        for (int p = 0; p < 7; p++) drive_px(8'($urandom));
        @(negedge clk);
        ram_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors += 3;
        if (wt_ready !== 1'b0) begin miscompares++; $display("FAIL midrst wt_ready: got %b want 0", wt_ready); end
        if (out_vld !== 1'b0 || frame_done !== 1'b0) begin
            miscompares++; $display("FAIL midrst valids: got %b%b want 00", out_vld, frame_done);
        end
        if (dout !== '0) begin miscompares++; $display("FAIL midrst dout: got %h want 0", dout); end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd = n_obs;
        rand_nw();
        load_nw(NW);
        send_frame(0, 1, '0);
        check_results("midrst_frame");
    endtask

    task automatic test_back_to_back();
        int first, nfd;
        rand_nw();
        load_nw(NW);
        first = rd;
        send_frame(0, 1, '0);
        send_frame(0, 1, '0);
        check_results("b2b");
        nfd = 0;
        for (int k = first; k < n_obs; k++) if (obs_fd[k]) nfd++;
        vectors += 2;
        if (n_obs - first != 8) begin miscompares++; $display("FAIL b2b count: got %0d want 8", n_obs - first); end
        if (nfd != 2) begin miscompares++; $display("FAIL b2b frame_done: got %0d want 2", nfd); end
        // Same frame twice in a row: stale data from frame 1 must not leak.
        first = rd;
        send_frame(0, 0, 8'h35);
        send_frame(0, 0, 8'h35);
        check_results("b2b_same");
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (obs_d[first+4+k] !== obs_d[first+k]) begin
                miscompares++;
                $display("FAIL b2b repeat[%0d]: got %h want %h", k, obs_d[first+4+k], obs_d[first+k]);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_saturation();
        test_no_weights();
        test_gaps();
        test_reset_midframe();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
